// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw pins in, conditioned levels and pulses out.
// Handshake: there is no valid/ready pair. held is a level. pressed, released and strobe
// are single-cycle pulses in the clk domain with no backpressure, so the consumer must
// sample them on every clock. rpt_state exposes the per-channel repeat FSM (2 bits each).
interface button_conditioner_if #(
  parameter int N = 8
);
  logic [N-1:0]   raw_btn;
  logic [N-1:0]   held;
  logic [N-1:0]   pressed;
  logic [N-1:0]   released;
  logic [N-1:0]   strobe;
  logic [2*N-1:0] rpt_state;

  // master: board / game logic side
  modport master (
    output raw_btn,
    input  held, pressed, released, strobe, rpt_state
  );

  // slave: the conditioner itself
  modport slave (
    input  raw_btn,
    output held, pressed, released, strobe, rpt_state
  );
endinterface

// File: rtl/button_conditioner.sv
// N-channel push-button front end: 2-FF synchroniser, counter debounce,
// press/release pulses and optional per-channel auto-repeat.
// Optional feature macro: BTN_AUTOREPEAT_EN (repeat FSMs built when defined;
// otherwise strobe == pressed on every channel).
module button_conditioner #(
  parameter int                   N_BUTTONS           = 8,
  parameter int                   RAW_ACTIVE_LOW      = 1,
  parameter int                   DEBOUNCE_CYCLES     = 500_000,
  parameter int                   REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int                   REPEAT_RATE_CYCLES  = 5_000_000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK         = N_BUTTONS'(8'h0F)
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  localparam int            DW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_SAT  = {DW{1'b1}};

  // Repeat FSM encoding, also the value seen on btn.rpt_state
  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rpt_state_t;

  // Reject configurations the counters cannot represent
  if (DEBOUNCE_CYCLES < 2 || REPEAT_RATE_CYCLES < 1 || REPEAT_DELAY_CYCLES < 1 ||
      $bits(REPEAT_MASK) != N_BUTTONS) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter set");
  end

  logic [N_BUTTONS-1:0] raw_norm;
  logic [N_BUTTONS-1:0] sync_1;
  logic [N_BUTTONS-1:0] sync_q;
  logic [N_BUTTONS-1:0] held_q;
  logic [N_BUTTONS-1:0] pressed_q;
  logic [N_BUTTONS-1:0] released_q;
  logic [N_BUTTONS-1:0] strobe_q;
  logic [N_BUTTONS-1:0] accept;
  logic [N_BUTTONS-1:0] press_evt;
  logic [N_BUTTONS-1:0] release_evt;
  logic [N_BUTTONS-1:0] held_nxt;
  logic [N_BUTTONS-1:0] rpt_fire;
  logic [DW-1:0]        cnt [N_BUTTONS];

  // Normalise polarity so 1 always means pressed from here on
  assign raw_norm = (RAW_ACTIVE_LOW != 0) ? ~btn.raw_btn : btn.raw_btn;

  // Two-flop synchroniser; reset loads the released level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= '0;
      sync_q <= '0;
    end else begin
      sync_1 <= raw_norm;
      sync_q <= sync_1;
    end
  end

  // A change is accepted once it has been stable for DEBOUNCE_CYCLES synced cycles
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      accept[i] = (sync_q[i] != held_q[i]) && (cnt[i] == DB_LAST);
    end
  end

  assign press_evt   = accept & ~held_q;
  assign release_evt = accept & held_q;
  assign held_nxt    = held_q ^ accept;

  // Debounce counters: clear while input matches held level or on acceptance, else saturating count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (sync_q[i] == held_q[i] || accept[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != DB_SAT) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered outputs: pulses coincide with the first cycle of the new held level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      strobe_q   <= '0;
    end else begin
      held_q     <= held_nxt;
      pressed_q  <= press_evt;
      released_q <= release_evt;
      strobe_q   <= press_evt | rpt_fire;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                        REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int            RW        = $clog2(RMAX) + 1;
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYCLES - 1);
  localparam logic [RW-1:0] R_SAT     = {RW{1'b1}};

  rpt_state_t           rpt_st [N_BUTTONS];
  logic [RW-1:0]        rcnt   [N_BUTTONS];
  logic [2*N_BUTTONS-1:0] rpt_dbg;

  // Timer expiry fires a repeat only while the button stays held (release wins)
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (REPEAT_MASK[i] && held_nxt[i]) begin
        rpt_fire[i] = ((rpt_st[i] == R_DELAY)  && (rcnt[i] == DLY_LAST)) ||
                      ((rpt_st[i] == R_REPEAT) && (rcnt[i] == RATE_LAST));
      end
    end
  end

  // Per-channel repeat FSM: IDLE -> DELAY on press, DELAY -> REPEAT at first expiry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        rpt_st[i] <= R_IDLE;
        rcnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!REPEAT_MASK[i] || !held_nxt[i]) begin
          rpt_st[i] <= R_IDLE;
          rcnt[i]   <= '0;
        end else begin
          case (rpt_st[i])
            R_IDLE: begin
              if (press_evt[i]) begin
                rpt_st[i] <= R_DELAY;
                rcnt[i]   <= '0;
              end
            end
            R_DELAY: begin
              if (rcnt[i] == DLY_LAST) begin
                rpt_st[i] <= R_REPEAT;
                rcnt[i]   <= '0;
              end else if (rcnt[i] != R_SAT) begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            R_REPEAT: begin
              if (rcnt[i] == RATE_LAST) begin
                rcnt[i] <= '0;
              end else if (rcnt[i] != R_SAT) begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            default: begin
              rpt_st[i] <= R_IDLE;
              rcnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Pack FSM states for observation
  always_comb begin
    rpt_dbg = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      rpt_dbg[2*i +: 2] = rpt_st[i];
    end
  end

  assign btn.rpt_state = rpt_dbg;
`else
  assign rpt_fire      = '0;
  assign btn.rpt_state = '0;
`endif

  assign btn.held     = held_q;
  assign btn.pressed  = pressed_q;
  assign btn.released = released_q;
  assign btn.strobe   = strobe_q;

endmodule
